// File: rtl/btn_evt_pkg.sv
// Shared constants for the button event generator: counter width,
// default thresholds and FSM state codes.
package btn_evt_pkg;

  localparam int CNT_W = 16;

  localparam logic [CNT_W-1:0] LONG_CYCLES_DEF   = 16'd50000;
  localparam logic [CNT_W-1:0] REPEAT_CYCLES_DEF = 16'd10000;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_PRESS = 2'd1;
  localparam state_t ST_LONG  = 2'd2;

endpackage

// File: rtl/btn_edge_det.sv
// Edge detector for the debounced button level. The previous sample
// resets high so a button held through reset is not seen as a new press.
module btn_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic rise,
  output logic fall
);

  logic btn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= 1'b1;
    end else begin
      btn_q <= btn_in;
    end
  end

  assign rise = btn_in & ~btn_q;
  assign fall = ~btn_in & btn_q;

endmodule

// File: rtl/btn_event_gen.sv
// Button event generator: turns a debounced level into press, release,
// short, long and auto-repeat pulses plus a held flag and short-press count.
module btn_event_gen
  import btn_evt_pkg::*;
#(
  parameter logic [CNT_W-1:0] LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter logic [CNT_W-1:0] REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter bit               REPEAT_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  logic             rise;
  logic             fall;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  btn_edge_det u_edge (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_in),
    .rise   (rise),
    .fall   (fall)
  );

  // Outside IDLE the last sample was high, so "no fall" means the button is
  // still held; a fall therefore always wins over a counter expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      press_count   <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (rise) begin
            press_pulse <= 1'b1;
            cnt         <= '0;
            state       <= ST_PRESS;
            held        <= 1'b1;
          end
        end

        ST_PRESS: begin
          if (fall) begin
            release_pulse <= 1'b1;
            short_pulse   <= 1'b1;
            press_count   <= press_count + 8'd1;
            state         <= ST_IDLE;
            held          <= 1'b0;
          end else if (cnt == LONG_CYCLES - 16'd1) begin
            long_pulse <= 1'b1;
            cnt        <= '0;
            state      <= ST_LONG;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        ST_LONG: begin
          if (fall) begin
            release_pulse <= 1'b1;
            state         <= ST_IDLE;
            held          <= 1'b0;
          end else if (cnt == REPEAT_CYCLES - 16'd1) begin
            repeat_pulse <= REPEAT_EN;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// Scoreboard bench for btn_event_gen: one DUT with auto-repeat, one without,
// both fed the same randomized button holds and checked against event lists.
module tb_btn_event_gen;

  localparam int LI = 8;
  localparam int RI = 4;

  typedef struct {
    int         cyc;
    logic [4:0] pulses;
    logic [7:0] count;
  } evt_t;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;

  logic       press_a, release_a, short_a, long_a, repeat_a, held_a;
  logic       press_b, release_b, short_b, long_b, repeat_b, held_b;
  logic [7:0] count_a, count_b;

  logic [4:0] pulses [2];
  logic       held   [2];
  logic [7:0] counts [2];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  evt_t exp_q  [2][$];
  int   held_q [2][$];
  int   model_count [2];
  int   held_run [2];

  btn_event_gen #(
    .LONG_CYCLES   (16'd8),
    .REPEAT_CYCLES (16'd4),
    .REPEAT_EN     (1'b1)
  ) dut_a (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .press_pulse   (press_a),
    .release_pulse (release_a),
    .short_pulse   (short_a),
    .long_pulse    (long_a),
    .repeat_pulse  (repeat_a),
    .held          (held_a),
    .press_count   (count_a)
  );

  btn_event_gen #(
    .LONG_CYCLES   (16'd8),
    .REPEAT_CYCLES (16'd4),
    .REPEAT_EN     (1'b0)
  ) dut_b (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .press_pulse   (press_b),
    .release_pulse (release_b),
    .short_pulse   (short_b),
    .long_pulse    (long_b),
    .repeat_pulse  (repeat_b),
    .held          (held_b),
    .press_count   (count_b)
  );

  assign pulses[0] = {press_a, release_a, short_a, long_a, repeat_a};
  assign pulses[1] = {press_b, release_b, short_b, long_b, repeat_b};
  assign held[0]   = held_a;
  assign held[1]   = held_b;
  assign counts[0] = count_a;
  assign counts[1] = count_b;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic report_fail(input string name, input int i, input int want_cyc);
    checks++;
    failures++;
    $display("[TB] FAIL %s dut%0d: expected at cycle %0d, seen at cycle %0d", name, i, want_cyc, cyc);
  endtask

  // Expected events of one hold, given press at sampling edge k and the
  // number of sampled-high edges.
  task automatic push_press(input int k, input int hold);
    for (int i = 0; i < 2; i++) begin
      exp_q[i].push_back('{cyc: k, pulses: 5'b10000, count: 8'(model_count[i])});
      if (hold <= LI) begin
        model_count[i] = (model_count[i] + 1) % 256;
        exp_q[i].push_back('{cyc: k + hold, pulses: 5'b01100, count: 8'(model_count[i])});
      end else begin
        exp_q[i].push_back('{cyc: k + LI, pulses: 5'b00010, count: 8'(model_count[i])});
        if (i == 0) begin
          for (int t = LI + RI; t < hold; t += RI)
            exp_q[i].push_back('{cyc: k + t, pulses: 5'b00001, count: 8'(model_count[i])});
        end
        exp_q[i].push_back('{cyc: k + hold, pulses: 5'b01000, count: 8'(model_count[i])});
      end
      held_q[i].push_back(hold);
    end
  endtask

  task automatic applyStimulus(input int hold, input int gap);
    @(posedge clk);
    #1;
    btn_in = 1'b1;
    push_press(cyc + 1, hold);
    repeat (hold) @(posedge clk);
    #1;
    btn_in = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q[0].size() + exp_q[1].size() + held_q[0].size() + held_q[1].size()) > 0
           && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    for (int i = 0; i < 2; i++) begin
      if (exp_q[i].size() + held_q[i].size() > 0) begin
        report_fail("drain timeout", i, -1);
        exp_q[i].delete();
        held_q[i].delete();
      end
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    evt_t e;
    for (int i = 0; i < 2; i++) begin
      while (exp_q[i].size() > 0 && exp_q[i][0].cyc < cyc) begin
        e = exp_q[i].pop_front();
        report_fail($sformatf("missing event 0x%0h", e.pulses), i, e.cyc);
      end
      if (pulses[i] != 5'b0) begin
        if (exp_q[i].size() > 0 && exp_q[i][0].cyc == cyc) begin
          e = exp_q[i].pop_front();
          checkOutput($sformatf("dut%0d pulses", i), 32'(pulses[i]), 32'(e.pulses));
          checkOutput($sformatf("dut%0d press_count", i), 32'(counts[i]), 32'(e.count));
        end else begin
          report_fail($sformatf("unexpected pulses 0x%0h", pulses[i]), i, -1);
        end
      end
      if (held[i]) begin
        held_run[i]++;
      end else if (held_run[i] > 0) begin
        if (held_q[i].size() > 0)
          checkOutput($sformatf("dut%0d held length", i), 32'(held_run[i]), 32'(held_q[i].pop_front()));
        else
          report_fail("unexpected held", i, -1);
        held_run[i] = 0;
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1;
    btn_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      model_count[i] = 0;
      held_run[i] = 0;
    end

    repeat (2) @(posedge clk);
    #2;
    checkOutput("dut0 outputs in reset", 32'({pulses[0], held[0], counts[0]}), 32'd0);
    checkOutput("dut1 outputs in reset", 32'({pulses[1], held[1], counts[1]}), 32'd0);

    // Button held through reset release must not register as a press.
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    btn_in = 1'b0;
    repeat (2) @(posedge clk);

    applyStimulus(5, 3);
    drain();
    checkOutput("dut0 count after short", 32'(counts[0]), 32'(model_count[0]));

    applyStimulus(20, 3);
    drain();

    // Reset while PRESS is at cnt=3: press discarded, no release afterwards.
    @(posedge clk);
    #1;
    btn_in = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      exp_q[i].push_back('{cyc: k, pulses: 5'b10000, count: 8'(model_count[i])});
      held_q[i].push_back(3);
    end
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("dut0 async reset outputs", 32'({pulses[0], held[0], counts[0]}), 32'd0);
    checkOutput("dut1 async reset outputs", 32'({pulses[1], held[1], counts[1]}), 32'd0);
    for (int i = 0; i < 2; i++) model_count[i] = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    btn_in = 1'b0;
    repeat (2) @(posedge clk);
    applyStimulus(10, 2);
    drain();

    for (int n = 0; n < 256; n++)
      applyStimulus(int'($urandom_range(1, LI)), int'($urandom_range(0, 3)));
    drain();
    checkOutput("dut0 count wrap", 32'(counts[0]), 32'(model_count[0]));
    checkOutput("dut1 count wrap", 32'(counts[1]), 32'(model_count[1]));

    applyStimulus(3, 2);
    drain();
    checkOutput("dut0 count after 257", 32'(counts[0]), 32'(model_count[0]));

    for (int n = 0; n < 30; n++)
      applyStimulus(int'($urandom_range(1, 30)), int'($urandom_range(0, 4)));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
